ahb_apb_arbiter: RTL and testbench

AHB_APB_ARBITER -- requirements
Module: ahb_apb_arbiter

---
 rtl/ahb_apb_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_ahb_apb_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_apb_arbiter.sv
// Two-master arbiter in front of one shared AHB-to-APB bridge slave port.
// Each master has an IDLE/WAIT/ADDR/DATA machine; held transfers are issued one at a time.
module ahb_apb_arbiter #(
    parameter int TPD = 1
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic [3:0]  MHTRANS,
    input  logic [63:0] MHADDR,
    input  logic [63:0] MHWDATA,
    input  logic [1:0]  MHWRITE,
    input  logic [1:0]  MHMASTLOCK,
    input  logic [5:0]  MHSIZE,
    input  logic [7:0]  MHPROT,
    output logic [1:0]  MHREADY,
    output logic [1:0]  MHRESP,
    output logic [31:0] MHRDATA,
    output logic        S_HSEL,
    output logic [31:0] S_HADDR,
    output logic        S_HWRITE,
    output logic [1:0]  S_HTRANS,
    output logic [2:0]  S_HSIZE,
    output logic [2:0]  S_HBURST,
    output logic        S_HMASTLOCK,
    output logic [3:0]  S_HPROT,
    output logic [31:0] S_HWDATA,
    output logic        S_HREADYIN,
    input  logic        S_HREADYOUT,
    input  logic        S_HRESP,
    input  logic [31:0] S_HRDATA
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ADDR = 2'b10,
        ST_DATA = 2'b11
    } state_e;

    logic [1:0]  is_idle_s;
    logic [1:0]  is_wait_s;
    logic [1:0]  is_addr_s;
    logic [1:0]  is_data_s;
    logic [1:0]  capture_s;
    logic [1:0]  to_idle_s;
    logic [1:0]  win_s;
    logic [1:0]  elig_s;
    logic [63:0] hold_addr_s;
    logic [1:0]  hold_write_s;
    logic [5:0]  hold_size_s;
    logic [7:0]  hold_prot_s;
    logic [1:0]  hold_lock_s;
    logic        grant_s;
    logic        winner_s;
    logic        addr_next_s;
    logic        ptr_q;
    logic        ptr_d;
    logic        lock_held_q;
    logic        lock_held_d;
    logic        lock_owner_q;
    logic        lock_owner_d;
    logic        unused_s;

    // TPD only matters to delay-annotated models; the synthesizable outputs carry no delay.
    assign unused_s = ^{MHTRANS[2], MHTRANS[0], (TPD != 0)};

    for (genvar n = 0; n < 2; n++) begin : g_master
        localparam logic ID = 1'(n);

        state_e      state_q;
        state_e      state_d;
        logic [31:0] addr_q;
        logic        write_q;
        logic        lock_q;
        logic [2:0]  size_q;
        logic [3:0]  prot_q;

        assign is_idle_s[n] = (state_q == ST_IDLE);
        assign is_wait_s[n] = (state_q == ST_WAIT);
        assign is_addr_s[n] = (state_q == ST_ADDR);
        assign is_data_s[n] = (state_q == ST_DATA);
        assign MHREADY[n]   = is_idle_s[n] | (is_data_s[n] & S_HREADYOUT);
        assign MHRESP[n]    = is_data_s[n] & S_HRESP;
        assign capture_s[n] = MHREADY[n] & MHTRANS[2*n+1];
        assign to_idle_s[n] = is_data_s[n] & S_HREADYOUT & ~MHTRANS[2*n+1];
        assign win_s[n]     = grant_s & (winner_s == ID);

        // Per-master state register
        always_ff @(posedge HCLK or negedge HRESETN) begin
            if (!HRESETN) begin
                state_q <= ST_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // Per-master next state
        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_IDLE: begin
                    if (capture_s[n]) state_d = ST_WAIT;
                    else              state_d = ST_IDLE;
                end
                ST_WAIT: begin
                    if (win_s[n]) state_d = ST_ADDR;
                    else          state_d = ST_WAIT;
                end
                ST_ADDR: begin
                    if (S_HREADYOUT) state_d = ST_DATA;
                    else             state_d = ST_ADDR;
                end
                ST_DATA: begin
                    if (!S_HREADYOUT)      state_d = ST_DATA;
                    else if (capture_s[n]) state_d = ST_WAIT;
                    else                   state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Address-phase holding register, loaded whenever the master's transfer is accepted
        always_ff @(posedge HCLK or negedge HRESETN) begin
            if (!HRESETN) begin
                addr_q  <= 32'h0;
                write_q <= 1'b0;
                lock_q  <= 1'b0;
                size_q  <= 3'b000;
                prot_q  <= 4'b0000;
            end else if (capture_s[n]) begin
                addr_q  <= MHADDR[32*n +: 32];
                write_q <= MHWRITE[n];
                lock_q  <= MHMASTLOCK[n];
                size_q  <= MHSIZE[3*n +: 3];
                prot_q  <= MHPROT[4*n +: 4];
            end
        end

        assign hold_addr_s[32*n +: 32] = addr_q;
        assign hold_write_s[n]         = write_q;
        assign hold_lock_s[n]          = lock_q;
        assign hold_size_s[3*n +: 3]   = size_q;
        assign hold_prot_s[4*n +: 4]   = prot_q;
    end

    // A held lock shuts the non-owner out of arbitration entirely.
    assign elig_s[0]   = is_wait_s[0] & ~(lock_held_q & lock_owner_q);
    assign elig_s[1]   = is_wait_s[1] & ~(lock_held_q & ~lock_owner_q);
    assign grant_s     = (|elig_s) & (~(|is_addr_s) | S_HREADYOUT);
    assign winner_s    = (elig_s == 2'b11) ? ptr_q : elig_s[1];
    assign addr_next_s = grant_s | ((|is_addr_s) & ~S_HREADYOUT);

    // Round-robin pointer and lock ownership next state
    always_comb begin
        ptr_d        = ptr_q;
        lock_held_d  = lock_held_q;
        lock_owner_d = lock_owner_q;
        if (grant_s && (elig_s == 2'b11)) begin
            ptr_d = ~winner_s;
        end else begin
            ptr_d = ptr_q;
        end
        if (grant_s && hold_lock_s[winner_s]) begin
            lock_held_d  = 1'b1;
            lock_owner_d = winner_s;
        end else if (grant_s && lock_held_q && (winner_s == lock_owner_q)) begin
            lock_held_d = 1'b0;
        end else if (lock_held_q && to_idle_s[lock_owner_q] && !MHMASTLOCK[lock_owner_q]) begin
            lock_held_d = 1'b0;
        end else begin
            lock_held_d = lock_held_q;
        end
    end

    // Arbitration state registers
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            ptr_q        <= 1'b0;
            lock_held_q  <= 1'b0;
            lock_owner_q <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            lock_held_q  <= lock_held_d;
            lock_owner_q <= lock_owner_d;
        end
    end

    // Slave address phase; loaded at issue so it holds its last value once the slot empties
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            S_HSEL      <= 1'b0;
            S_HTRANS    <= 2'b00;
            S_HADDR     <= 32'h0;
            S_HWRITE    <= 1'b0;
            S_HSIZE     <= 3'b000;
            S_HPROT     <= 4'b0000;
            S_HMASTLOCK <= 1'b0;
        end else begin
            S_HSEL   <= addr_next_s;
            S_HTRANS <= addr_next_s ? 2'b10 : 2'b00;
            if (grant_s) begin
                S_HADDR     <= winner_s ? hold_addr_s[63:32] : hold_addr_s[31:0];
                S_HWRITE    <= hold_write_s[winner_s];
                S_HSIZE     <= winner_s ? hold_size_s[5:3] : hold_size_s[2:0];
                S_HPROT     <= winner_s ? hold_prot_s[7:4] : hold_prot_s[3:0];
                S_HMASTLOCK <= hold_lock_s[winner_s];
            end
        end
    end

    assign S_HBURST   = 3'b000;
    assign S_HWDATA   = is_data_s[1] ? MHWDATA[63:32] : MHWDATA[31:0];
    assign S_HREADYIN = S_HREADYOUT;
    assign MHRDATA    = S_HRDATA;

endmodule

// File: tb/tb_ahb_apb_arbiter.sv
// Directed self-checking bench for ahb_apb_arbiter; the bench plays both masters and the bridge.
module tb_ahb_apb_arbiter;

    logic        HCLK;
    logic        HRESETN;
    logic [3:0]  MHTRANS;
    logic [63:0] MHADDR;
    logic [63:0] MHWDATA;
    logic [1:0]  MHWRITE;
    logic [1:0]  MHMASTLOCK;
    logic [5:0]  MHSIZE;
    logic [7:0]  MHPROT;
    logic [1:0]  MHREADY;
    logic [1:0]  MHRESP;
    logic [31:0] MHRDATA;
    logic        S_HSEL;
    logic [31:0] S_HADDR;
    logic        S_HWRITE;
    logic [1:0]  S_HTRANS;
    logic [2:0]  S_HSIZE;
    logic [2:0]  S_HBURST;
    logic        S_HMASTLOCK;
    logic [3:0]  S_HPROT;
    logic [31:0] S_HWDATA;
    logic        S_HREADYIN;
    logic        S_HREADYOUT;
    logic        S_HRESP;
    logic [31:0] S_HRDATA;

    int n_checks = 0;
    int n_errors = 0;

    ahb_apb_arbiter #(.TPD(1)) dut (
        .HCLK        (HCLK),
        .HRESETN     (HRESETN),
        .MHTRANS     (MHTRANS),
        .MHADDR      (MHADDR),
        .MHWDATA     (MHWDATA),
        .MHWRITE     (MHWRITE),
        .MHMASTLOCK  (MHMASTLOCK),
        .MHSIZE      (MHSIZE),
        .MHPROT      (MHPROT),
        .MHREADY     (MHREADY),
        .MHRESP      (MHRESP),
        .MHRDATA     (MHRDATA),
        .S_HSEL      (S_HSEL),
        .S_HADDR     (S_HADDR),
        .S_HWRITE    (S_HWRITE),
        .S_HTRANS    (S_HTRANS),
        .S_HSIZE     (S_HSIZE),
        .S_HBURST    (S_HBURST),
        .S_HMASTLOCK (S_HMASTLOCK),
        .S_HPROT     (S_HPROT),
        .S_HWDATA    (S_HWDATA),
        .S_HREADYIN  (S_HREADYIN),
        .S_HREADYOUT (S_HREADYOUT),
        .S_HRESP     (S_HRESP),
        .S_HRDATA    (S_HRDATA)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic m_req(input int n, input logic [31:0] addr, input logic wr, input logic lk);
        MHTRANS[2*n +: 2]  = 2'b10;
        MHADDR[32*n +: 32] = addr;
        MHWRITE[n]         = wr;
        MHMASTLOCK[n]      = lk;
        MHSIZE[3*n +: 3]   = 3'b010;
        MHPROT[4*n +: 4]   = 4'b0011;
    endtask

    task automatic m_idle(input int n, input logic lk);
        MHTRANS[2*n +: 2] = 2'b00;
        MHMASTLOCK[n]     = lk;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_mhready"}, MHREADY, 2'b11);
        check_val({pfx, "_mhresp"}, MHRESP, 2'b00);
        check_val({pfx, "_hsel"}, S_HSEL, 1'b0);
        check_val({pfx, "_htrans"}, S_HTRANS, 2'b00);
        check_val({pfx, "_haddr"}, S_HADDR, 32'h0);
        check_val({pfx, "_hwrite"}, S_HWRITE, 1'b0);
        check_val({pfx, "_hmastlock"}, S_HMASTLOCK, 1'b0);
    endtask

    initial begin
        HRESETN     = 1'b0;
        MHTRANS     = 4'h0;
        MHADDR      = 64'h0;
        MHWDATA     = 64'h0;
        MHWRITE     = 2'b00;
        MHMASTLOCK  = 2'b00;
        MHSIZE      = 6'h0;
        MHPROT      = 8'h0;
        S_HREADYOUT = 1'b1;
        S_HRESP     = 1'b0;
        S_HRDATA    = 32'h0;

        #12;
        check_reset_outputs("rst");
        HRESETN = 1'b1;
        cyc();

        // Single write from M0
        m_req(0, 32'h0200_0010, 1'b1, 1'b0);
        settle();
        check_val("wr_idle_ready", MHREADY[0], 1'b1);
        cyc();
        m_idle(0, 1'b0);
        MHWDATA[31:0] = 32'h1234_5678;
        settle();
        check_val("wr_wait_ready", MHREADY[0], 1'b0);
        check_val("wr_wait_hsel", S_HSEL, 1'b0);
        cyc();
        check_val("wr_addr_hsel", S_HSEL, 1'b1);
        check_val("wr_addr_htrans", S_HTRANS, 2'b10);
        check_val("wr_addr_haddr", S_HADDR, 32'h0200_0010);
        check_val("wr_addr_hwrite", S_HWRITE, 1'b1);
        check_val("wr_addr_hsize", S_HSIZE, 3'b010);
        check_val("wr_addr_hprot", S_HPROT, 4'b0011);
        check_val("wr_addr_hburst", S_HBURST, 3'b000);
        check_val("wr_addr_ready", MHREADY[0], 1'b0);
        cyc();
        check_val("wr_data_ready", MHREADY[0], 1'b1);
        check_val("wr_data_hwdata", S_HWDATA, 32'h1234_5678);
        check_val("wr_data_hsel", S_HSEL, 1'b0);
        check_val("wr_data_htrans", S_HTRANS, 2'b00);
        cyc();
        check_val("wr_done_ready", MHREADY[0], 1'b1);
        check_val("wr_done_haddr_hold", S_HADDR, 32'h0200_0010);

        // Simultaneous requests: M0 then M1
        m_req(0, 32'h0000_0100, 1'b0, 1'b0);
        m_req(1, 32'h0000_0200, 1'b0, 1'b0);
        cyc();
        m_idle(0, 1'b0);
        m_idle(1, 1'b0);
        settle();
        check_val("sim_wait_ready", MHREADY, 2'b00);
        cyc();
        check_val("sim_m0_hsel", S_HSEL, 1'b1);
        check_val("sim_m0_haddr", S_HADDR, 32'h0000_0100);
        check_val("sim_m0_ready", MHREADY, 2'b00);
        cyc();
        check_val("sim_m1_hsel", S_HSEL, 1'b1);
        check_val("sim_m1_haddr", S_HADDR, 32'h0000_0200);
        check_val("sim_m1_ready", MHREADY, 2'b01);
        cyc();
        S_HREADYOUT = 1'b0;
        settle();
        check_val("sim_m1_data_stall", MHREADY, 2'b01);
        check_val("sim_m1_data_hsel", S_HSEL, 1'b0);
        cyc();
        check_val("sim_m1_data_stall2", MHREADY, 2'b01);
        S_HREADYOUT = 1'b1;
        settle();
        check_val("sim_m1_data_done", MHREADY, 2'b11);
        cyc();

        // Locked sequence from M1 while M0 waits
        m_req(1, 32'h3000_0000, 1'b1, 1'b1);
        cyc();
        m_idle(1, 1'b1);
        m_req(0, 32'h4000_0000, 1'b0, 1'b0);
        cyc();
        m_idle(0, 1'b0);
        settle();
        check_val("lk1_haddr", S_HADDR, 32'h3000_0000);
        check_val("lk1_hmastlock", S_HMASTLOCK, 1'b1);
        cyc();
        m_req(1, 32'h3000_0004, 1'b1, 1'b1);
        settle();
        check_val("lk1_data_hsel", S_HSEL, 1'b0);
        cyc();
        m_idle(1, 1'b1);
        settle();
        check_val("lk2_wait_hsel", S_HSEL, 1'b0);
        cyc();
        check_val("lk2_haddr", S_HADDR, 32'h3000_0004);
        cyc();
        m_req(1, 32'h3000_0008, 1'b1, 1'b1);
        cyc();
        m_idle(1, 1'b1);
        settle();
        check_val("lk3_wait_hsel", S_HSEL, 1'b0);
        cyc();
        check_val("lk3_haddr", S_HADDR, 32'h3000_0008);
        check_val("lk3_m0_ready", MHREADY[0], 1'b0);
        cyc();
        m_idle(1, 1'b0);
        settle();
        check_val("lk3_data_hsel", S_HSEL, 1'b0);
        cyc();
        check_val("lk_release_m0_ready", MHREADY[0], 1'b0);
        cyc();
        check_val("lk_m0_hsel", S_HSEL, 1'b1);
        check_val("lk_m0_haddr", S_HADDR, 32'h4000_0000);
        check_val("lk_m0_hmastlock", S_HMASTLOCK, 1'b0);
        cyc();
        cyc();

        // Error response on an M0 read; M1 stays idle and unaffected
        m_req(0, 32'h0000_0300, 1'b0, 1'b0);
        cyc();
        m_idle(0, 1'b0);
        cyc();
        cyc();
        S_HREADYOUT = 1'b0;
        S_HRESP     = 1'b1;
        settle();
        check_val("err_c1_resp", MHRESP, 2'b01);
        check_val("err_c1_ready", MHREADY, 2'b10);
        cyc();
        S_HREADYOUT = 1'b1;
        settle();
        check_val("err_c2_resp", MHRESP, 2'b01);
        check_val("err_c2_ready", MHREADY, 2'b11);
        cyc();
        S_HRESP = 1'b0;
        settle();
        check_val("err_after_resp", MHRESP, 2'b00);
        check_val("err_after_ready", MHREADY, 2'b11);

        // Reset pulsed while M1 sits in a locked write data phase
        m_req(1, 32'h5000_0004, 1'b1, 1'b1);
        cyc();
        m_idle(1, 1'b1);
        cyc();
        cyc();
        S_HREADYOUT = 1'b0;
        S_HRESP     = 1'b1;
        settle();
        check_val("mid_pre_ready", MHREADY[1], 1'b0);
        check_val("mid_pre_haddr", S_HADDR, 32'h5000_0004);
        check_val("mid_pre_hwrite", S_HWRITE, 1'b1);
        check_val("mid_pre_hmastlock", S_HMASTLOCK, 1'b1);
        #1;
        HRESETN = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        m_idle(1, 1'b0);
        S_HREADYOUT = 1'b1;
        S_HRESP     = 1'b0;
        #2;
        HRESETN = 1'b1;
        cyc();
        m_req(0, 32'h0600_0020, 1'b0, 1'b0);
        cyc();
        m_idle(0, 1'b0);
        cyc();
        check_val("post_rst_hsel", S_HSEL, 1'b1);
        check_val("post_rst_haddr", S_HADDR, 32'h0600_0020);
        cyc();
        check_val("post_rst_data_ready", MHREADY, 2'b11);
        cyc();

        // Four slave wait states on an M0 read
        m_req(0, 32'h0000_1000, 1'b0, 1'b0);
        cyc();
        m_idle(0, 1'b0);
        cyc();
        cyc();
        S_HREADYOUT = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_val($sformatf("ws_stall%0d", i), MHREADY[0], 1'b0);
            cyc();
        end
        S_HREADYOUT = 1'b1;
        S_HRDATA    = 32'hA5A5_0001;
        settle();
        check_val("ws_done_ready", MHREADY[0], 1'b1);
        check_val("ws_done_rdata", MHRDATA, 32'hA5A5_0001);
        check_val("ws_hreadyin", S_HREADYIN, 1'b1);
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
